// File: rtl/tinyalu_req_pkg.sv
`default_nettype none
// ============================================================================
// tinyalu_req_pkg : shared types and widths for the TinyALU command requester
// Revision 1.0
// ============================================================================
package tinyalu_req_pkg;

    localparam int OPND_W = 8;
    localparam int RES_W  = 16;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_MULT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } cmd_t;

    function automatic logic is_single_cycle(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tinyalu_req_fifo.sv
`default_nettype none
// ============================================================================
// tinyalu_req_fifo : synchronous command FIFO with registered push-side ready
// Revision 1.0
// ============================================================================
module tinyalu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    assign do_push    = push_valid && ready_q;
    assign do_pop     = pop && (count_q != '0);
    assign empty      = (count_q == '0);
    assign push_ready = ready_q;
    assign head_data  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        ready_d  = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tinyalu_requester.sv
`default_nettype none
// ============================================================================
// tinyalu_requester : queues ALU commands, drives the TinyALU start/op/A/B
// protocol and returns one response per command. Optional done-timeout is
// enabled with `define TINYALU_REQ_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
module tinyalu_requester
    import tinyalu_req_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic [OP_W-1:0]   rsp_op,
    output logic              rsp_err,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result,
    output logic              busy
);
    state_e            state_q, state_d;
    logic              prev_idle_q, prev_idle_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [OPND_W-1:0] a_q, a_d;
    logic [OPND_W-1:0] b_q, b_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [OP_W-1:0]   rop_q, rop_d;
    logic              err_q, err_d;

    cmd_t push_cmd;
    cmd_t head;
    logic fifo_empty;
    logic fifo_pop;
    logic launch;
    logic start_now;
    logic timed_out;

    assign push_cmd = {cmd_op, cmd_a, cmd_b};

    tinyalu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (cmd_valid),
        .push_ready (cmd_ready),
        .push_data  (push_cmd),
        .pop        (fifo_pop),
        .head_data  (head),
        .empty      (fifo_empty)
    );

`ifdef TINYALU_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT));
`else
    // Without the counter TIMEOUT has no effect and this is constant low.
    assign timed_out = (TIMEOUT < 0);
`endif

    // Launch only after a full IDLE cycle so alu_start always has a low gap.
    assign launch = (state_q == ST_IDLE) && prev_idle_q && !fifo_empty;

    always_comb begin
        state_d     = state_q;
        prev_idle_d = (state_q == ST_IDLE);
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        rop_d       = rop_q;
        err_d       = err_q;
        fifo_pop    = 1'b0;
        start_now   = 1'b0;
`ifdef TINYALU_REQ_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    fifo_pop = 1'b1;
                    op_d     = head.op;
                    a_d      = head.a;
                    b_d      = head.b;
                    rop_d    = head.op;
`ifdef TINYALU_REQ_TIMEOUT_EN
                    // The launch cycle itself counts as the first waited cycle.
                    cnt_d    = CNT_W'(2);
`endif
                    if (is_single_cycle(head.op)) begin
                        state_d   = ST_SINGLE;
                        start_now = 1'b1;
                    end else if (head.op == OP_MUL) begin
                        state_d   = ST_MULT;
                        start_now = 1'b1;
                    end else begin
                        res_d   = '0;
                        err_d   = (head.op != OP_NOP);
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SINGLE, ST_MULT: begin
                if (alu_done) begin
                    res_d   = alu_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timed_out) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
`ifdef TINYALU_REQ_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            prev_idle_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            rop_q       <= '0;
            err_q       <= 1'b0;
`ifdef TINYALU_REQ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prev_idle_q <= prev_idle_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            rop_q       <= rop_d;
            err_q       <= err_d;
`ifdef TINYALU_REQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign alu_start  = start_now || (state_q == ST_MULT);
    assign alu_op     = launch ? head.op : op_q;
    assign alu_a      = launch ? head.a  : a_q;
    assign alu_b      = launch ? head.b  : b_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = res_q;
    assign rsp_op     = rop_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_requester.sv
`default_nettype none
// ============================================================================
// tb_tinyalu_requester : directed bench with a behavioural TinyALU model
// Revision 1.0
// ============================================================================
module tb_tinyalu_requester;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        busy;

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   start_cycles = 0;
    logic hang = 1'b0;
    logic [2:0] mcnt;

    always #5 clk = ~clk;

    tinyalu_requester #(
        .DEPTH   (4),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .busy       (busy)
    );

    // TinyALU model: single ops answer the cycle after start, MUL three cycles later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_done   <= 1'b0;
            alu_result <= 16'h0;
            mcnt       <= 3'd0;
        end else begin
            alu_done   <= 1'b0;
            alu_result <= 16'hDEAD;
            if (!alu_start) begin
                mcnt <= 3'd0;
            end else if (!alu_done && !hang) begin
                if (alu_op == 3'd4) begin
                    if (mcnt == 3'd2) begin
                        alu_done   <= 1'b1;
                        alu_result <= {8'd0, alu_a} * {8'd0, alu_b};
                    end else begin
                        mcnt <= mcnt + 3'd1;
                    end
                end else begin
                    alu_done <= 1'b1;
                    case (alu_op)
                        3'd1:    alu_result <= {8'd0, alu_a} + {8'd0, alu_b};
                        3'd2:    alu_result <= {8'd0, alu_a & alu_b};
                        3'd3:    alu_result <= {8'd0, alu_a ^ alu_b};
                        default: alu_result <= 16'hBAD0;
                    endcase
                end
            end
        end
    end

    always @(posedge clk) begin
        if (alu_start) start_cycles <= start_cycles + 1;
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    task automatic wait_rsp(input string tag);
        int k = 0;
        while (!rsp_valid && k < 50) begin
            cyc();
            k++;
        end
        chk(tag, 32'(rsp_valid), 32'd1);
    endtask

    logic [7:0]  xa [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h5A};
    logic [7:0]  xb [5] = '{8'h5A, 8'h0F, 8'hFF, 8'h81, 8'h18};
    logic [15:0] xr [5] = '{16'h00FF, 16'h0033, 16'h0000, 16'h0081, 16'h0042};

    initial begin
        int s0;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0; rsp_ready = 1'b0;
        cyc(2);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outs", 32'({rsp_valid, alu_start, busy, rsp_err}), 32'd0);
        chk("rst_result", 32'(rsp_result), 32'd0);
        reset_n = 1'b1;
        cyc();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // ADD 200 + 100
        s0 = start_cycles;
        push(3'd1, 8'd200, 8'd100); cyc(); cmd_valid = 1'b0;
        chk("add_start_n1", 32'(alu_start), 32'd1);
        chk("add_opnds", 32'({alu_op, alu_a, alu_b}), 32'({3'd1, 8'd200, 8'd100}));
        cyc();
        chk("add_start_n2", 32'(alu_start), 32'd0);
        chk("add_done_n2", 32'(alu_done), 32'd1);
        cyc();
        chk("add_rsp", 32'({rsp_valid, rsp_err, rsp_op}), 32'({1'b1, 1'b0, 3'd1}));
        chk("add_result", 32'(rsp_result), 32'd300);
        chk("add_start_len", 32'(start_cycles - s0), 32'd1);
        rsp_ready = 1'b1; cyc();
        chk("add_rsp_taken", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0; cyc();

        // MUL 255 * 255
        push(3'd4, 8'd255, 8'd255); cyc(); cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("mul_hold_n%0d", k), 32'({alu_start, alu_op, alu_a, alu_b}),
                32'({1'b1, 3'd4, 8'd255, 8'd255}));
            if (k < 4) cyc();
        end
        chk("mul_done_n4", 32'({alu_done, rsp_valid}), 32'({1'b1, 1'b0}));
        cyc();
        chk("mul_n5", 32'({alu_start, rsp_valid, rsp_err}), 32'({1'b0, 1'b1, 1'b0}));
        chk("mul_result", 32'(rsp_result), 32'd65025);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0; cyc();

        // NOP then illegal opcode 110
        s0 = start_cycles;
        push(3'd0, 8'h12, 8'h34); cyc(); push(3'd6, 8'h56, 8'h78);
        chk("nop_no_start", 32'(alu_start), 32'd0);
        cyc(); cmd_valid = 1'b0;
        chk("nop_rsp", 32'({rsp_valid, rsp_err, rsp_op}), 32'({1'b1, 1'b0, 3'd0}));
        chk("nop_result", 32'(rsp_result), 32'd0);
        rsp_ready = 1'b1; cyc();
        chk("nop_taken_busy", 32'({rsp_valid, busy}), 32'({1'b0, 1'b1}));
        rsp_ready = 1'b0; cyc();
        chk("ill_gap", 32'(rsp_valid), 32'd0);
        cyc();
        chk("ill_rsp", 32'({rsp_valid, rsp_err, rsp_op}), 32'({1'b1, 1'b1, 3'd6}));
        chk("ill_result", 32'(rsp_result), 32'd0);
        chk("nop_ill_no_start", 32'(start_cycles - s0), 32'd0);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0; cyc();

        // Back-to-back AND then ADD with rsp_ready held high
        rsp_ready = 1'b1;
        push(3'd2, 8'hF0, 8'h3C); cyc(); push(3'd1, 8'hFF, 8'h01);
        chk("b2b_and_start", 32'({alu_start, alu_op}), 32'({1'b1, 3'd2}));
        cyc(); cmd_valid = 1'b0;
        cyc();
        chk("b2b_and_rsp", 32'({rsp_valid, rsp_result}), 32'({1'b1, 16'h0030}));
        cyc();
        chk("b2b_gap", 32'(alu_start), 32'd0);
        cyc();
        chk("b2b_add_start", 32'({alu_start, alu_op, alu_a, alu_b}), 32'({1'b1, 3'd1, 8'hFF, 8'h01}));
        cyc(2);
        chk("b2b_add_rsp", 32'({rsp_valid, rsp_result}), 32'({1'b1, 16'h0100}));
        cyc(); rsp_ready = 1'b0; cyc();

        // Fill the FIFO under response backpressure
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_ready_%0d", i), 32'(cmd_ready), 32'd1);
            push(3'd3, xa[i], xb[i]); cyc();
        end
        push(3'd3, 8'hEE, 8'hEE);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        cyc(3);
        chk("full_hold_ready", 32'(cmd_ready), 32'd0);
        chk("full_hold_rsp", 32'({rsp_valid, rsp_result}), 32'({1'b1, 16'h00FF}));
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp($sformatf("drain_valid_%0d", i));
            chk($sformatf("drain_result_%0d", i), 32'(rsp_result), 32'(xr[i]));
            cyc();
        end
        cyc(5);
        chk("drain_idle", 32'({rsp_valid, busy, cmd_ready}), 32'({1'b0, 1'b0, 1'b1}));
        rsp_ready = 1'b0;

        // Reset in the middle of a MUL with another command queued
        push(3'd4, 8'd3, 8'd5); cyc(); push(3'd1, 8'd1, 8'd1);
        chk("rmul_start", 32'(alu_start), 32'd1);
        cyc(); cmd_valid = 1'b0; reset_n = 1'b0;
        cyc();
        chk("rmul_outs", 32'({alu_start, rsp_valid, cmd_ready, busy, rsp_err}), 32'd0);
        chk("rmul_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
        chk("rmul_result", 32'(rsp_result), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("rmul_quiet_%0d", k), 32'({rsp_valid, alu_start, busy}), 32'd0);
        end
        chk("rmul_ready", 32'(cmd_ready), 32'd1);

`ifdef TINYALU_REQ_TIMEOUT_EN
        // ALU never answers: AND then MUL must time out after 8 cycles
        hang = 1'b1;
        push(3'd2, 8'h0F, 8'hF0); cyc(); cmd_valid = 1'b0;
        cyc(7);
        chk("to_and_n8", 32'(rsp_valid), 32'd0);
        cyc();
        chk("to_and_n9", 32'({rsp_valid, rsp_err, alu_start}), 32'({1'b1, 1'b1, 1'b0}));
        chk("to_and_result", 32'(rsp_result), 32'd0);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0; cyc();
        push(3'd4, 8'h10, 8'h10); cyc(); cmd_valid = 1'b0;
        cyc(7);
        chk("to_mul_n8", 32'({alu_start, rsp_valid}), 32'({1'b1, 1'b0}));
        cyc();
        chk("to_mul_n9", 32'({alu_start, rsp_valid, rsp_err}), 32'({1'b0, 1'b1, 1'b1}));
        chk("to_mul_result", 32'(rsp_result), 32'd0);
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0; hang = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tinyalu_requester.md
# tinyalu_requester

Command-side initiator for the TinyALU datapath. It accepts ALU commands on a valid/ready stream and buffers them in a small FIFO. It drives the ALU's `start`/`op`/`A`/`B` pins under the single-cycle and multi-cycle protocol rules, captures `result` on `done`, and returns one response per command on a valid/ready response stream. It sits between the testbench/CPU-side command source and the TinyALU core, on the opposite end of the ALU protocol from the core itself.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `TIMEOUT`, 8: cycles to wait for `alu_done` after `alu_start` first rises.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full (registered).
- `cmd_op`  in  3  opcode (000 nop, 001 add, 010 and, 011 xor, 100 mul).
- `cmd_a`, `cmd_b`  in  8 each  operands.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_result`  out  16  captured result.
- `rsp_op`  out  3  opcode of the completed command.
- `rsp_err`  out  1  illegal opcode or timeout.
- `alu_start`  out  1  to ALU `start`.
- `alu_op`  out  3  to ALU `op`.
- `alu_a`, `alu_b`  out  8 each  to ALU `A`, `B`.
- `alu_done`  in  1  from ALU `done`.
- `alu_result`  in  16  from ALU `result`.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- **Reset:**
  - All outputs are 0, including `cmd_ready`. `cmd_ready` rises on the first edge after reset deasserts.
  - Reset flushes the FIFO. An op in flight at reset is dropped with no response.
- **FSM states:** IDLE, SINGLE, MULT, RESP.
- **IDLE:**
  - If the FIFO is non-empty, pop the head and load `alu_op`/`alu_a`/`alu_b`.
  - Ops 001–011: go to SINGLE and assert `alu_start`.
  - Op 100: go to MULT and assert `alu_start`.
  - Op 000: never started on the ALU. Load `rsp_result`=0, `rsp_err`=0, go to RESP.
  - Ops 101–111: rejected without starting. Load `rsp_result`=0, `rsp_err`=1, go to RESP.
- **SINGLE:**
  - `alu_start` is high for exactly one cycle.
  - `alu_done` is expected the cycle after `alu_start`. Capture `alu_result` in the cycle `alu_done`=1, then go to RESP.
- **MULT:**
  - `alu_start`, `alu_op`, `alu_a`, `alu_b` are held stable until `alu_done`=1 is sampled.
  - Capture the result in that cycle. `alu_start` drops the next cycle, then go to RESP.
- **RESP:**
  - `rsp_valid`=1 with `rsp_*` stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - `alu_start` is always low for at least one cycle between consecutive ALU ops.
- **Spurious `alu_done`:** ignored in IDLE and RESP.
- **Width rules:**
  - `rsp_result` takes the full 16-bit `alu_result` for every op, with no masking.
  - The FIFO stores `{op,a,b}`, 19 bits.
- **FIFO:**
  - Push on `cmd_valid && cmd_ready`. No bypass: a push into an empty FIFO is visible to the FSM next cycle.
  - Full: `cmd_ready`=0.
  - Simultaneous push and pop while not full: both take effect and the count is unchanged.
  - Pointers wrap modulo `DEPTH`.

## Timing
Command handshake in cycle n, FSM IDLE, FIFO empty:
- **add/and/xor:**
  - n+1: `alu_start`=1.
  - n+2: `alu_done`=1 and `alu_start`=0.
  - n+3: `rsp_valid`=1.
- **mul:**
  - n+1: `alu_start`=1.
  - n+4: `alu_done`=1, `alu_start` still 1.
  - n+5: `alu_start`=0 and `rsp_valid`=1.
- **nop or illegal opcode:** `rsp_valid`=1 at n+2, with no `alu_start`.
- **Back-to-back:** after the response handshake in cycle m, the next queued op asserts `alu_start` at m+2 at the earliest.

## Configuration
- `TINYALU_REQ_TIMEOUT_EN` defined:
  - A counter starts when `alu_start` rises.
  - If `alu_done` is not seen within `TIMEOUT` cycles, drop `alu_start`, respond with `rsp_result`=0, `rsp_err`=1, and go to RESP.
  - A `done` arriving after the timeout is ignored.
- Macro undefined: no counter; the FSM waits in SINGLE/MULT indefinitely. `rsp_err` is then driven only by illegal opcodes.

## Structure
- Package `tinyalu_req_pkg`:
  - `op_e` enum (NOP, ADD, AND, XOR, MUL).
  - `state_e` enum.
  - Command struct `{op,a,b}`.
  - Width constants 8/16/3.
- One sub-module `tinyalu_req_fifo`: parameterised sync FIFO with full/empty and registered ready.

## Test plan
- **Reset mid-MUL:** `reset_n` low at cycle n+2 → all outputs 0 next edge, no response after release, FIFO empty.
- **ADD:** A=200, B=100 → `alu_start` one cycle; `rsp_result`=300, `rsp_err`=0 at n+3.
- **MUL:** A=255, B=255 → `alu_a`/`alu_b`/`alu_op` stable n+1..n+4; `rsp_result`=65025 at n+5.
- **Nop and illegal opcode:** op 000 then op 110 → `alu_start` never rises; responses (0, err 0) then (0, err 1).
- **Fill and backpressure:** push DEPTH+1 XOR commands with `rsp_ready`=0 → `cmd_ready` drops once full; `rsp_valid` and `rsp_result` held; releasing `rsp_ready` drains all results in order.
- **Timeout (macro defined, TIMEOUT=8):** ALU model never asserts `done` on AND → `rsp_err`=1, `rsp_result`=0, `alu_start` low after 8 cycles.
